// File: rtl/eclair_seq_pkg.sv
// Shared encodings for the ECLair control-store sequencer.
package eclair_seq_pkg;

    typedef enum logic [2:0] {
        SEQ_NEXT    = 3'd0,
        SEQ_JUMP    = 3'd1,
        SEQ_JUMP_IF = 3'd2,
        SEQ_CALL    = 3'd3,
        SEQ_RET     = 3'd4,
        SEQ_HOLD    = 3'd5
    } seq_op_e;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_e;

endpackage

// File: rtl/seq_stack.sv
// Synchronous LIFO holding microcode return addresses.
module seq_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [IW-1:0]    w_top_idx;
    logic [IW-1:0]    w_wr_idx;

    // r_ptr counts entries; the top of stack sits one below it.
    assign w_top_idx = IW'(r_ptr - PW'(1));
    assign w_wr_idx  = IW'(r_ptr);
    assign o_data    = r_mem[w_top_idx];
    assign o_full    = (r_ptr == PW'(DEPTH));
    assign o_empty   = (r_ptr == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_push && !o_full) begin
            r_ptr <= r_ptr + PW'(1);
        end else if (i_pop && !o_empty) begin
            r_ptr <= r_ptr - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/cs_sequencer.sv
// Control-store sequencer: copies ROM into RAM after reset, then steps microcode.
module cs_sequencer
    import eclair_seq_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter int unsigned           WORD_WIDTH  = 64,
    parameter int unsigned           STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR   = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 2)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] rom_data,
    output logic [ADDR_WIDTH-1:0] cs_addr,
    output logic                  cs_we,
    output logic [WORD_WIDTH-1:0] cs_wdata,
    input  logic [2:0]            seq_op,
    input  logic                  jump_src,
    input  logic [ADDR_WIDTH-1:0] ir,
    input  logic [ADDR_WIDTH-1:0] jump_addr_mc,
    input  logic                  cond,
    input  logic                  resume,
    output logic                  cs_ready,
    output logic                  halted,
    output logic                  stack_err
);

    seq_state_e            r_state;
    seq_state_e            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [ADDR_WIDTH-1:0] w_stack_top;
    logic                  r_ready;
    logic                  r_halted;
    logic                  r_err;
    logic                  w_err_nxt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;

    assign w_addr_inc = r_addr + ADDR_WIDTH'(1);
    assign w_target   = jump_src ? jump_addr_mc : ir;

    seq_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_addr_inc),
        .o_data  (w_stack_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_err_nxt   = r_err;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_addr_nxt = w_addr_inc;
                if (r_addr == '1) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_addr == HALT_ADDR) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    case (seq_op)
                        SEQ_JUMP:    w_addr_nxt = w_target;
                        SEQ_JUMP_IF: w_addr_nxt = cond ? w_target : w_addr_inc;
                        SEQ_CALL: begin
                            if (w_full) begin
                                w_err_nxt   = 1'b1;
                                w_state_nxt = ST_HALTED;
                            end else begin
                                w_push     = 1'b1;
                                w_addr_nxt = w_target;
                            end
                        end
                        SEQ_RET: begin
                            if (w_empty) begin
                                w_err_nxt   = 1'b1;
                                w_state_nxt = ST_HALTED;
                            end else begin
                                w_pop      = 1'b1;
                                w_addr_nxt = w_stack_top;
                            end
                        end
                        SEQ_HOLD: w_addr_nxt = r_addr;
                        default:  w_addr_nxt = w_addr_inc;
                    endcase
                end
            end
            ST_HALTED: begin
                // A stack fault is terminal until reset.
                if (resume && !r_err) begin
                    w_state_nxt = ST_RUN;
                    w_addr_nxt  = w_addr_inc;
                end
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_LOAD;
            r_addr   <= '0;
            r_ready  <= 1'b0;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_ready  <= (w_state_nxt != ST_LOAD);
            r_halted <= (w_state_nxt == ST_HALTED);
            r_err    <= w_err_nxt;
        end
    end

    assign cs_addr   = r_addr;
    assign cs_we     = (r_state == ST_LOAD);
    assign cs_wdata  = rom_data;
    assign cs_ready  = r_ready;
    assign halted    = r_halted;
    assign stack_err = r_err;

endmodule

// File: tb/tb_cs_sequencer.sv
// Scoreboard bench for cs_sequencer: directed steps queue expected outputs, a monitor checks them.
module tb_cs_sequencer;
    import eclair_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] rom_data;
    logic [7:0]  cs_addr;
    logic        cs_we;
    logic [63:0] cs_wdata;
    logic [2:0]  seq_op;
    logic        jump_src;
    logic [7:0]  ir;
    logic [7:0]  jump_addr_mc;
    logic        cond;
    logic        resume;
    logic        cs_ready;
    logic        halted;
    logic        stack_err;

    always #5 clk = ~clk;

    assign rom_data = {56'd0, cs_addr};

    cs_sequencer #(
        .ADDR_WIDTH  (8),
        .WORD_WIDTH  (64),
        .STACK_DEPTH (4),
        .HALT_ADDR   (8'hFE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rom_data     (rom_data),
        .cs_addr      (cs_addr),
        .cs_we        (cs_we),
        .cs_wdata     (cs_wdata),
        .seq_op       (seq_op),
        .jump_src     (jump_src),
        .ir           (ir),
        .jump_addr_mc (jump_addr_mc),
        .cond         (cond),
        .resume       (resume),
        .cs_ready     (cs_ready),
        .halted       (halted),
        .stack_err    (stack_err)
    );

    typedef struct {
        int unsigned stamp;
        string       nm;
        logic [7:0]  addr;
        logic        ready;
        logic        hlt;
        logic        err;
        logic        we;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s got %0h want %0h", nm, fld, act, want);
        end
    endtask

    // Entries are stamped with the cycle (edge count) after which they must be visible.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].stamp <= cyc) begin
            mon_e = q.pop_front();
            chk(mon_e.nm, "cycle", 64'(cyc), 64'(mon_e.stamp));
            chk(mon_e.nm, "cs_addr", 64'(cs_addr), 64'(mon_e.addr));
            chk(mon_e.nm, "cs_ready", 64'(cs_ready), 64'(mon_e.ready));
            chk(mon_e.nm, "halted", 64'(halted), 64'(mon_e.hlt));
            chk(mon_e.nm, "stack_err", 64'(stack_err), 64'(mon_e.err));
            chk(mon_e.nm, "cs_we", 64'(cs_we), 64'(mon_e.we));
            chk(mon_e.nm, "cs_wdata", cs_wdata, {56'd0, mon_e.addr});
        end
    end

    task automatic drv(input logic [2:0] op, input logic src, input logic [7:0] ja,
                       input logic [7:0] irv, input logic c, input logic res);
        seq_op       = op;
        jump_src     = src;
        jump_addr_mc = ja;
        ir           = irv;
        cond         = c;
        resume       = res;
    endtask

    task automatic step(input string nm, input logic [7:0] a, input logic rdy,
                        input logic hlt, input logic err, input logic we);
        exp_t e;
        e.stamp = cyc + 1;
        e.nm    = nm;
        e.addr  = a;
        e.ready = rdy;
        e.hlt   = hlt;
        e.err   = err;
        e.we    = we;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired with %0d expectations pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drv(SEQ_NEXT, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        step("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Load phase must ignore sequencing inputs.
        reset = 1'b0;
        drv(SEQ_JUMP, 1'b1, 8'h33, 8'h44, 1'b1, 1'b1);
        for (int i = 1; i < 256; i++) step("load", 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
        step("load_done", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        drv(SEQ_JUMP, 1'b1, 8'hFD, 8'h00, 1'b0, 1'b0);
        step("jump_fd", 8'hFD, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(SEQ_NEXT, 1'b1, 8'hFD, 8'h00, 1'b0, 1'b0);
        step("next_fe", 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(SEQ_JUMP, 1'b1, 8'h40, 8'h00, 1'b0, 1'b0);
        step("halt", 8'hFE, 1'b1, 1'b1, 1'b0, 1'b0);
        step("halt_hold", 8'hFE, 1'b1, 1'b1, 1'b0, 1'b0);
        drv(SEQ_NEXT, 1'b1, 8'h40, 8'h00, 1'b0, 1'b1);
        step("resume", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(SEQ_NEXT, 1'b1, 8'h40, 8'h00, 1'b0, 1'b0);
        step("wrap", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(SEQ_HOLD, 1'b1, 8'h40, 8'h00, 1'b0, 1'b0);
        step("hold", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(3'd6, 1'b1, 8'h40, 8'h00, 1'b1, 1'b0);
        step("op6", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(3'd7, 1'b1, 8'h40, 8'h00, 1'b1, 1'b0);
        step("op7", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(SEQ_JUMP_IF, 1'b1, 8'h40, 8'h12, 1'b0, 1'b0);
        step("jif_c0", 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(SEQ_JUMP_IF, 1'b1, 8'h40, 8'h12, 1'b1, 1'b0);
        step("jif_c1", 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(SEQ_JUMP, 1'b0, 8'h40, 8'h12, 1'b0, 1'b0);
        step("jump_ir", 8'h12, 1'b1, 1'b0, 1'b0, 1'b0);

        drv(SEQ_JUMP, 1'b1, 8'h10, 8'h12, 1'b0, 1'b0);
        step("jump_10", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(SEQ_CALL, 1'b1, 8'h80, 8'h12, 1'b0, 1'b0);
        step("call1", 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(SEQ_NEXT, 1'b1, 8'h80, 8'h12, 1'b0, 1'b0);
        step("next_81", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(SEQ_CALL, 1'b1, 8'h90, 8'h12, 1'b0, 1'b0);
        step("call2", 8'h90, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(SEQ_RET, 1'b1, 8'h55, 8'h12, 1'b0, 1'b0);
        step("ret1", 8'h82, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ret2", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ret_empty", 8'h11, 1'b1, 1'b1, 1'b1, 1'b0);
        drv(SEQ_NEXT, 1'b1, 8'h55, 8'h12, 1'b0, 1'b1);
        step("resume_ign", 8'h11, 1'b1, 1'b1, 1'b1, 1'b0);

        reset = 1'b1;
        drv(SEQ_NEXT, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        step("reset2", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        for (int i = 1; i <= 8'h37; i++) step("load2", 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        step("reset_mid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        for (int i = 1; i < 256; i++) step("reload", 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
        step("reload_done", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        drv(SEQ_CALL, 1'b1, 8'h20, 8'h00, 1'b0, 1'b0);
        step("ovf_c1", 8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(SEQ_CALL, 1'b1, 8'h30, 8'h00, 1'b0, 1'b0);
        step("ovf_c2", 8'h30, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(SEQ_CALL, 1'b1, 8'h40, 8'h00, 1'b0, 1'b0);
        step("ovf_c3", 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(SEQ_CALL, 1'b1, 8'h50, 8'h00, 1'b0, 1'b0);
        step("ovf_c4", 8'h50, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(SEQ_CALL, 1'b1, 8'h60, 8'h00, 1'b0, 1'b0);
        step("ovf_c5", 8'h50, 1'b1, 1'b1, 1'b1, 1'b0);
        drv(SEQ_NEXT, 1'b1, 8'h60, 8'h00, 1'b0, 1'b1);
        step("ovf_resume", 8'h50, 1'b1, 1'b1, 1'b1, 1'b0);
        drv(SEQ_NEXT, 1'b1, 8'h60, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) chk("drain", "pending", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
